// File: rtl/spi_shift_mstr.sv
// 16-bit SPI master, CPOL=1/CPHA=1, MSB-first full-duplex shifter.
// SCLK is the MSB of a free-running divider that only counts while active.
module spi_shift_mstr #(
  parameter int DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [DIV_W-1:0] DIV_ONES = '1;
  localparam logic [DIV_W-1:0] DIV_HALF =
    {1'b1, {(DIV_W-1){1'b0}}};
  localparam logic [DIV_W-1:0] DIV_PRE =
    {1'b0, {(DIV_W-1){1'b1}}};

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [3:0]       bit_cnt;
  logic [15:0]      shft;
  logic             miso_smpl;
  logic             porch;
  logic             ss_n_q;
  logic             done_q;

  // porch marks the first SCLK fall, which only opens the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div       <= DIV_ONES;
      bit_cnt   <= 4'd0;
      shft      <= 16'h0000;
      miso_smpl <= 1'b0;
      porch     <= 1'b0;
      ss_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wrt) begin
            shft    <= cmd;
            div     <= DIV_HALF;
            bit_cnt <= 4'd0;
            porch   <= 1'b1;
            ss_n_q  <= 1'b0;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (bit_cnt == 4'd15 && div == DIV_ONES) begin
            shft   <= {shft[14:0], miso_smpl};
            ss_n_q <= 1'b1;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            div <= div + DIV_W'(1);
            if (div == DIV_PRE)
              miso_smpl <= MISO;
            if (div == DIV_ONES) begin
              if (porch) begin
                porch <= 1'b0;
              end else begin
                shft    <= {shft[14:0], miso_smpl};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SCLK    = div[DIV_W-1];
  assign SS_n    = ss_n_q;
  assign MOSI    = shft[15];
  assign done    = done_q;
  assign rd_data = shft;

endmodule

// File: tb/tb_spi_shift_mstr.sv
// Bench for spi_shift_mstr: directed scenarios plus random words,
// checked against a word-level slave/latency model.
module tb_spi_shift_mstr;

  logic        clk;
  logic        rst;
  logic        wrt;
  logic [15:0] cmd;
  logic        MISO;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        done;
  logic [15:0] rd_data;

  int checks;
  int errors;

  // Word-level slave: drives the next bit after every SCLK fall
  logic        loopb;
  logic [15:0] sword;
  logic [15:0] mosi_w;
  logic        prev_sclk;
  int          rises;
  int          falls;
  int          dones;

  localparam int LAT = 16 * 32 + 16;

  spi_shift_mstr #(.DIV_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .done    (done),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prev_sclk && !SCLK) begin
      if (loopb)
        MISO = MOSI;
      else if (falls < 16)
        MISO = sword[15 - falls];
      falls = falls + 1;
    end
    if (!prev_sclk && SCLK) begin
      rises = rises + 1;
      mosi_w = {mosi_w[14:0], MOSI};
    end
    if (done)
      dones = dones + 1;
    prev_sclk = SCLK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] c,
                      input logic        lb,
                      input logic [15:0] sw,
                      input int          glitch,
                      input int          abort,
                      input logic        chain,
                      input logic [15:0] nc,
                      input logic        pre);
    int k;
    int lows;
    logic got;
    logic [15:0] exp;
    exp = lb ? c : sw;
    if (!pre) begin
      wrt = 1'b1;
      cmd = c;
    end
    loopb = lb;
    sword = sw;
    @(posedge clk);
    #1;
    wrt = 1'b0;
    rises = 0;
    falls = 0;
    dones = 0;
    mosi_w = 16'h0;
    chk("ss_low_start", {31'd0, SS_n}, 32'd0);
    lows = 1;
    k = 0;
    got = 1'b0;
    while (!got && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
      if (k == abort) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ss_n", {31'd0, SS_n}, 32'd1);
        chk("abort_sclk", {31'd0, SCLK}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        chk("abort_no_done", dones, 32'd0);
        return;
      end
      if (k == glitch) begin
        wrt = 1'b1;
        cmd = 16'hFFFF;
      end
      if (k == glitch + 1)
        wrt = 1'b0;
      if (done)
        got = 1'b1;
      else if (!SS_n)
        lows++;
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("latency", k, LAT);
    chk("rd_data", {16'd0, rd_data}, {16'd0, exp});
    chk("rises", rises, 32'd16);
    chk("falls", falls, 32'd16);
    chk("mosi_word", {16'd0, mosi_w}, {16'd0, c});
    chk("ss_low_span", lows, LAT);
    chk("ss_high_done", {31'd0, SS_n}, 32'd1);
    if (chain) begin
      wrt = 1'b1;
      cmd = nc;
    end else begin
      @(posedge clk);
      #1;
      chk("done_1cyc", {31'd0, done}, 32'd0);
      chk("rd_hold", {16'd0, rd_data}, {16'd0, exp});
      repeat (20) @(posedge clk);
      #1;
      chk("done_count", dones, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] rc;
    logic [15:0] rs;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    wrt = 1'b0;
    cmd = 16'h0;
    MISO = 1'b0;
    loopb = 1'b0;
    sword = 16'h0;
    mosi_w = 16'h0;
    prev_sclk = 1'b1;
    rises = 0;
    falls = 0;
    dones = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ss_n", {31'd0, SS_n}, 32'd1);
    chk("rst_sclk", {31'd0, SCLK}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    rst = 1'b0;
    rises = 0;
    falls = 0;
    dones = 0;
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_sclk_quiet", rises + falls, 32'd0);
    chk("idle_no_done", dones, 32'd0);

    xfer(16'hA55A, 1'b1, 16'h0, -1, -1, 1'b0, 16'h0, 1'b0);
    xfer(16'hA300, 1'b0, 16'h3C00, -1, -1, 1'b0, 16'h0, 1'b0);

    rs = 16'($urandom);
    xfer(16'h5AC3, 1'b0, rs, -1, -1, 1'b1, 16'h0D02, 1'b0);
    rs = 16'($urandom);
    xfer(16'h0D02, 1'b0, rs, -1, -1, 1'b0, 16'h0, 1'b1);

    rs = 16'($urandom);
    xfer(16'h1062, 1'b0, rs, 100, -1, 1'b0, 16'h0, 1'b0);

    rc = 16'($urandom);
    rs = 16'($urandom);
    xfer(rc, 1'b0, rs, -1, 200, 1'b0, 16'h0, 1'b0);
    rc = 16'($urandom);
    rs = 16'($urandom);
    xfer(rc, 1'b0, rs, -1, -1, 1'b0, 16'h0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rc = 16'($urandom);
      rs = 16'($urandom);
      xfer(rc, 1'($urandom_range(0, 1)), rs,
           -1, -1, 1'b0, 16'h0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
